bouncing_sprite: RTL and testbench

- Parametrised moving-object engine for the arcade playfield: holds one object's centre position and direction, steps it on each `animate` tick, and reflects it off all four playfield edges.
- Adds over the previous generation:
  - runtime per-axis speed;
  - edge clamping and reflection on all four edges;
  - a run/pause/freeze state machine;
  - a spawn/load interface;
  - bounce event pulses and a bounce counter.
- Sits between the frame-tick generator and the pixel/collision logic. Its bounding-box outputs feed the renderer and the collision checker.

---
 rtl/sprite_pkg.sv | 26 ++
 rtl/sprite_axis.sv | 75 +++++++
 rtl/bouncing_sprite.sv | 164 ++++++++++++++++
 tb/tb_bouncing_sprite.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the bouncing sprite engine.
//   state_t     : run/pause/freeze controller states
//   DIR_INC/DEC : direction encodings (1 = coordinate increasing)
//   clamp_coord : clamp an integer into [lo, hi]
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        FROZEN = 2'd3
    } state_t;

    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

    function automatic int clamp_coord(input int value, input int lo, input int hi);
        if (value < lo)
            return lo;
        else if (value > hi)
            return hi;
        else
            return value;
    endfunction

endpackage

// File: rtl/sprite_axis.sv
// One axis of the sprite: position/direction register with step, edge
// clamp + reflect, and spawn load.
// Ports:
//   clk, reset    : clock, synchronous active-low reset
//   step          : advance one tick this cycle
//   load          : load load_pos (clamped) and load_dir; wins over step
//   load_pos/dir  : spawn values
//   speed         : pixels per step
//   pos, dir      : registered centre coordinate and direction
//   bounce        : registered one-cycle reflect pulse
//   hit           : combinational, high on the cycle a reflecting step is taken
module sprite_axis
    import sprite_pkg::*;
#(
    parameter int LO       = 8,
    parameter int HI       = 631,
    parameter int INIT_POS = 320,
    parameter int INIT_DIR = 1,
    parameter int COORD_W  = 12,
    parameter int SPEED_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               step,
    input  logic               load,
    input  logic [COORD_W-1:0] load_pos,
    input  logic               load_dir,
    input  logic [SPEED_W-1:0] speed,
    output logic [COORD_W-1:0] pos,
    output logic               dir,
    output logic               bounce,
    output logic               hit
);

    localparam logic signed [COORD_W:0] LO_S = (COORD_W+1)'(LO);
    localparam logic signed [COORD_W:0] HI_S = (COORD_W+1)'(HI);

    logic signed [COORD_W:0] pos_s;
    logic signed [COORD_W:0] spd_s;
    logic signed [COORD_W:0] nxt;
    logic                    moving;

    // One extra signed bit so a step past either edge never wraps.
    always_comb begin
        pos_s  = signed'({1'b0, pos});
        spd_s  = signed'((COORD_W+1)'(speed));
        nxt    = (dir == DIR_INC) ? (pos_s + spd_s) : (pos_s - spd_s);
        moving = step && (speed != '0);
        hit    = 1'b0;
        if (moving)
            hit = (dir == DIR_INC) ? (nxt >= HI_S) : (nxt <= LO_S);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pos    <= COORD_W'(INIT_POS);
            dir    <= 1'(INIT_DIR);
            bounce <= 1'b0;
        end else if (load) begin
            pos    <= COORD_W'(clamp_coord(int'(load_pos), LO, HI));
            dir    <= load_dir;
            bounce <= 1'b0;
        end else if (hit) begin
            // Land exactly on the edge and turn around.
            pos    <= (dir == DIR_INC) ? COORD_W'(HI) : COORD_W'(LO);
            dir    <= ~dir;
            bounce <= 1'b1;
        end else begin
            if (moving)
                pos <= nxt[COORD_W-1:0];
            bounce <= 1'b0;
        end
    end

endmodule

// File: rtl/bouncing_sprite.sv
// Moving-object engine: one square sprite that steps on each animate tick
// while running and reflects off all four playfield edges.
// Ports:
//   clk, reset                 : clock, synchronous active-low reset
//   animate                    : frame tick, one step per high cycle in RUN
//   start, pause, freeze       : run control (freeze > spawn > start > pause)
//   spawn, spawn_x/y/xdir/ydir : load a new position and direction
//   speed_x, speed_y           : per-axis pixels per tick
//   x1, x2, y1, y2             : bounding box (centre -/+ HALF_SIZE)
//   x_dir, y_dir               : current directions
//   bounce_x, bounce_y         : one-cycle reflect pulses
//   bounce_cnt                 : saturating reflection count
//   running                    : registered (state == RUN)
module bouncing_sprite
    import sprite_pkg::*;
#(
    parameter int HALF_SIZE  = 8,
    parameter int INIT_X     = 320,
    parameter int INIT_Y     = 240,
    parameter int INIT_X_DIR = 1,
    parameter int INIT_Y_DIR = 1,
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int COORD_W    = 12,
    parameter int SPEED_W    = 4,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               animate,
    input  logic               start,
    input  logic               pause,
    input  logic               freeze,
    input  logic               spawn,
    input  logic [COORD_W-1:0] spawn_x,
    input  logic [COORD_W-1:0] spawn_y,
    input  logic               spawn_xdir,
    input  logic               spawn_ydir,
    input  logic [SPEED_W-1:0] speed_x,
    input  logic [SPEED_W-1:0] speed_y,
    output logic [COORD_W-1:0] x1,
    output logic [COORD_W-1:0] x2,
    output logic [COORD_W-1:0] y1,
    output logic [COORD_W-1:0] y2,
    output logic               x_dir,
    output logic               y_dir,
    output logic               bounce_x,
    output logic               bounce_y,
    output logic [CNT_W-1:0]   bounce_cnt,
    output logic               running
);

    if ((2*HALF_SIZE+1 > WIDTH) || (2*HALF_SIZE+1 > HEIGHT)) begin : g_size_check
        $fatal(1, "bouncing_sprite: sprite does not fit the playfield");
    end

    localparam logic [COORD_W-1:0] HS = COORD_W'(HALF_SIZE);

    state_t             state;
    logic               step;
    logic               hit_x;
    logic               hit_y;
    logic [COORD_W-1:0] x_pos;
    logic [COORD_W-1:0] y_pos;
    logic [CNT_W:0]     cnt_sum;

    // Freeze takes effect immediately, so a freezing cycle never moves.
    assign step = (state == RUN) && animate && !spawn && !freeze;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            running <= 1'b0;
        end else if (freeze) begin
            state   <= FROZEN;
            running <= 1'b0;
        end else if (spawn) begin
            if (state == FROZEN) begin
                state   <= IDLE;
                running <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: if (start) begin
                    state   <= RUN;
                    running <= 1'b1;
                end
                RUN: if (pause) begin
                    state   <= PAUSED;
                    running <= 1'b0;
                end
                PAUSED: if (start || !pause) begin
                    state   <= RUN;
                    running <= 1'b1;
                end
                default: begin
                    state   <= state;
                    running <= running;
                end
            endcase
        end
    end

    sprite_axis #(
        .LO       (HALF_SIZE),
        .HI       (WIDTH - 1 - HALF_SIZE),
        .INIT_POS (INIT_X),
        .INIT_DIR (INIT_X_DIR),
        .COORD_W  (COORD_W),
        .SPEED_W  (SPEED_W)
    ) u_axis_x (
        .clk      (clk),
        .reset    (reset),
        .step     (step),
        .load     (spawn),
        .load_pos (spawn_x),
        .load_dir (spawn_xdir),
        .speed    (speed_x),
        .pos      (x_pos),
        .dir      (x_dir),
        .bounce   (bounce_x),
        .hit      (hit_x)
    );

    sprite_axis #(
        .LO       (HALF_SIZE),
        .HI       (HEIGHT - 1 - HALF_SIZE),
        .INIT_POS (INIT_Y),
        .INIT_DIR (INIT_Y_DIR),
        .COORD_W  (COORD_W),
        .SPEED_W  (SPEED_W)
    ) u_axis_y (
        .clk      (clk),
        .reset    (reset),
        .step     (step),
        .load     (spawn),
        .load_pos (spawn_y),
        .load_dir (spawn_ydir),
        .speed    (speed_y),
        .pos      (y_pos),
        .dir      (y_dir),
        .bounce   (bounce_y),
        .hit      (hit_y)
    );

    // Counter updates on the same edge as the bounce pulses; the extra
    // sum bit detects overflow so the count sticks at all-ones.
    assign cnt_sum = {1'b0, bounce_cnt} + (CNT_W+1)'(hit_x) + (CNT_W+1)'(hit_y);

    always_ff @(posedge clk) begin
        if (!reset)
            bounce_cnt <= '0;
        else if (cnt_sum[CNT_W])
            bounce_cnt <= '1;
        else
            bounce_cnt <= cnt_sum[CNT_W-1:0];
    end

    assign x1 = x_pos - HS;
    assign x2 = x_pos + HS;
    assign y1 = y_pos - HS;
    assign y2 = y_pos + HS;

endmodule

// File: tb/tb_bouncing_sprite.sv
module tb_bouncing_sprite;

    logic        clk = 1'b0;
    logic        reset, animate, start, pause, freeze, spawn;
    logic [11:0] spawn_x, spawn_y;
    logic        spawn_xdir, spawn_ydir;
    logic [3:0]  speed_x, speed_y;
    logic [11:0] x1, x2, y1, y2;
    logic        x_dir, y_dir, bounce_x, bounce_y, running;
    logic [15:0] bounce_cnt;
    logic [11:0] s_x1, s_x2, s_y1, s_y2;
    logic        s_x_dir, s_y_dir, s_bounce_x, s_bounce_y, s_running;
    logic [1:0]  s_cnt;

    int n_cmp = 0;
    int n_err = 0;

    typedef enum {S_X1, S_X2, S_Y1, S_Y2, S_XD, S_YD, S_BX, S_BY, S_CNT, S_RUN, S_CNT2} sig_t;
    typedef struct {
        sig_t        sig;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    bouncing_sprite dut (
        .clk(clk), .reset(reset), .animate(animate), .start(start), .pause(pause),
        .freeze(freeze), .spawn(spawn), .spawn_x(spawn_x), .spawn_y(spawn_y),
        .spawn_xdir(spawn_xdir), .spawn_ydir(spawn_ydir), .speed_x(speed_x),
        .speed_y(speed_y), .x1(x1), .x2(x2), .y1(y1), .y2(y2), .x_dir(x_dir),
        .y_dir(y_dir), .bounce_x(bounce_x), .bounce_y(bounce_y),
        .bounce_cnt(bounce_cnt), .running(running)
    );

    // Same stimulus, 2-bit counter to exercise saturation.
    bouncing_sprite #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .animate(animate), .start(start), .pause(pause),
        .freeze(freeze), .spawn(spawn), .spawn_x(spawn_x), .spawn_y(spawn_y),
        .spawn_xdir(spawn_xdir), .spawn_ydir(spawn_ydir), .speed_x(speed_x),
        .speed_y(speed_y), .x1(s_x1), .x2(s_x2), .y1(s_y1), .y2(s_y2), .x_dir(s_x_dir),
        .y_dir(s_y_dir), .bounce_x(s_bounce_x), .bounce_y(s_bounce_y),
        .bounce_cnt(s_cnt), .running(s_running)
    );

    function automatic logic [31:0] observe(input sig_t s);
        case (s)
            S_X1:    return 32'(x1);
            S_X2:    return 32'(x2);
            S_Y1:    return 32'(y1);
            S_Y2:    return 32'(y2);
            S_XD:    return 32'(x_dir);
            S_YD:    return 32'(y_dir);
            S_BX:    return 32'(bounce_x);
            S_BY:    return 32'(bounce_y);
            S_CNT:   return 32'(bounce_cnt);
            S_RUN:   return 32'(running);
            default: return 32'(s_cnt);
        endcase
    endfunction

    task automatic push(input sig_t s, input int v);
        exp_t e;
        e.sig = s;
        e.exp = 32'(v);
        sb.push_back(e);
    endtask

    // Box expectation derived from a centre.
    task automatic push_box(input int cx, input int cy);
        push(S_X1, cx - 8);
        push(S_X2, cx + 8);
        push(S_Y1, cy - 8);
        push(S_Y2, cy + 8);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sig);
            n_cmp++;
            assert (obs === e.exp)
            else begin
                n_err++;
                $error("FAIL %s observed=%0d expected=%0d", e.sig.name(), obs, e.exp);
            end
        end
    endtask

    task automatic do_spawn(input int sx, input int sy, input logic dx, input logic dy);
        spawn = 1'b1; spawn_x = 12'(sx); spawn_y = 12'(sy);
        spawn_xdir = dx; spawn_ydir = dy;
        tick();
        spawn = 1'b0;
    endtask

    task automatic do_animate();
        animate = 1'b1;
        tick();
        animate = 1'b0;
    endtask

    initial begin
        reset = 1'b0; animate = 1'b0; start = 1'b0; pause = 1'b0; freeze = 1'b0;
        spawn = 1'b0; spawn_x = '0; spawn_y = '0; spawn_xdir = 1'b0; spawn_ydir = 1'b0;
        speed_x = 4'd1; speed_y = 4'd1;
        tick(); tick();
        reset = 1'b1;

        // Reset state
        push_box(320, 240); push(S_XD, 1); push(S_YD, 1);
        push(S_RUN, 0); push(S_CNT, 0); push(S_CNT2, 0); push(S_BX, 0);
        drain();

        // Animate in IDLE: no motion
        do_animate(); do_animate();
        push_box(320, 240); drain();

        start = 1'b1; tick(); start = 1'b0;
        push(S_RUN, 1); drain();

        // Right-edge reflection
        speed_x = 4'd5; speed_y = 4'd0;
        do_spawn(628, 240, 1'b1, 1'b1);
        push_box(628, 240); push(S_RUN, 1); drain();
        do_animate();
        push_box(631, 240); push(S_XD, 0); push(S_BX, 1); push(S_BY, 0);
        push(S_CNT, 1); push(S_CNT2, 1); drain();
        tick();
        push(S_BX, 0); push(S_X2, 639); drain();
        do_animate();
        push_box(626, 240); push(S_BX, 0); push(S_CNT, 1); drain();

        // Corner hit on the low edges
        speed_x = 4'd3; speed_y = 4'd3;
        do_spawn(10, 10, 1'b0, 1'b0);
        push_box(10, 10); drain();
        do_animate();
        push_box(8, 8); push(S_BX, 1); push(S_BY, 1); push(S_XD, 1); push(S_YD, 1);
        push(S_CNT, 3); push(S_CNT2, 3); drain();
        do_spawn(10, 10, 1'b0, 1'b0);
        push(S_BX, 0); push(S_BY, 0); drain();
        do_animate();
        push_box(8, 8); push(S_CNT, 5); push(S_CNT2, 3); drain();

        // Pause holds position
        pause = 1'b1; tick();
        push(S_RUN, 0); drain();
        for (int i = 0; i < 4; i++) do_animate();
        push_box(8, 8); drain();
        pause = 1'b0; tick();
        push(S_RUN, 1); drain();
        do_animate();
        push_box(11, 11); push(S_BX, 0); drain();

        // Spawn clamp, speed 0 on the bound: no bounce
        speed_x = 4'd0; speed_y = 4'd0;
        do_spawn(700, 0, 1'b1, 1'b0);
        push_box(631, 8); drain();
        do_animate();
        push_box(631, 8); push(S_BX, 0); push(S_BY, 0); push(S_CNT, 5); drain();

        // Freeze beats start; FROZEN ignores animate and start
        speed_x = 4'd2; speed_y = 4'd2;
        freeze = 1'b1; start = 1'b1; tick(); freeze = 1'b0; start = 1'b0;
        push(S_RUN, 0); drain();
        do_animate();
        push_box(631, 8); drain();
        start = 1'b1; tick(); start = 1'b0;
        push(S_RUN, 0); drain();
        do_spawn(100, 200, 1'b1, 1'b0);
        push_box(100, 200); push(S_RUN, 0); push(S_XD, 1); push(S_YD, 0); drain();
        do_animate();
        push_box(100, 200); drain();
        start = 1'b1; tick(); start = 1'b0;
        push(S_RUN, 1); drain();
        do_animate();
        push_box(102, 198); drain();

        // Reset mid-step wins
        animate = 1'b1; reset = 1'b0; tick(); animate = 1'b0; reset = 1'b1;
        push_box(320, 240); push(S_RUN, 0); push(S_CNT, 0); push(S_CNT2, 0);
        push(S_XD, 1); push(S_YD, 1); drain();
        do_animate();
        push_box(320, 240); drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
